// File: rtl/fifo_port_arbiter_if.sv
// Bundles the requester, consumer, memory-port and status signals of the shared FIFO controller.
// master is the controller side; slave is the requester/consumer/memory side.
interface fifo_port_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ASIZE      = 4,
  parameter int NREQ       = 4
);
  logic [NREQ-1:0]            req;
  logic [NREQ*DATA_WIDTH-1:0] req_data;
  logic [NREQ-1:0]            gnt;
  logic                       rd_req;
  logic                       rd_valid;
  logic                       mem_wen;
  logic [ASIZE-1:0]           mem_waddr;
  logic [DATA_WIDTH-1:0]      mem_wdata;
  logic                       mem_ren;
  logic [ASIZE-1:0]           mem_raddr;
  logic [ASIZE:0]             count;
  logic                       full;
  logic                       empty;
  logic                       threshold;
  logic                       overflow;
  logic                       underflow;
  logic                       flag_clr;

  modport master (
    input  req, req_data, rd_req, flag_clr,
    output gnt, rd_valid, mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr,
    output count, full, empty, threshold, overflow, underflow
  );

  modport slave (
    output req, req_data, rd_req, flag_clr,
    input  gnt, rd_valid, mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr,
    input  count, full, empty, threshold, overflow, underflow
  );
endinterface

// File: rtl/fifo_port_arbiter.sv
// Round-robin arbiter sharing one dual-port FIFO among NREQ writers; grant/mem_wen/mem_ren are same-cycle, rd_valid one cycle later.
// Writers are held off (gnt=0) while full; pops are ignored while empty; both raise sticky error flags.
module fifo_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ASIZE      = 4,
  parameter int NREQ       = 4,
  parameter int THRESH     = 12
) (
  input logic wclk,
  input logic rst,
  fifo_port_arbiter_if.master bus
);
  localparam int RW = $clog2(NREQ);
  localparam logic [ASIZE:0] PTR_ONE = (ASIZE+1)'(1);
  localparam logic [ASIZE:0] DEPTH   = (ASIZE+1)'(2**ASIZE);
  localparam logic [ASIZE:0] THR     = (ASIZE+1)'(THRESH);
  localparam logic [RW:0]    NREQ_W  = (RW+1)'(NREQ);

  logic [ASIZE:0] wr_ptr_q, wr_ptr_d;
  logic [ASIZE:0] rd_ptr_q, rd_ptr_d;
  logic [ASIZE:0] count_q, count_d;
  logic [RW-1:0]  rr_q, rr_d;
  logic           rd_valid_q, rd_valid_d;
  logic           overflow_q, overflow_d;
  logic           underflow_q, underflow_d;

  logic                  full_c, empty_c;
  logic [NREQ-1:0]       gnt_c;
  logic [RW-1:0]         gnt_idx;
  logic                  found;
  logic [RW:0]           sum;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic                  wen_c, ren_c;

  assign full_c  = (count_q == DEPTH);
  assign empty_c = (count_q == '0);

  // Search upward from rr with wrap; reset and full both suppress any grant.
  always_comb begin
    gnt_c   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    if (!rst && !full_c) begin
      for (int off = 0; off < NREQ; off++) begin
        sum = {1'b0, rr_q} + (RW+1)'(off);
        if (sum >= NREQ_W) sum = sum - NREQ_W;
        if (!found && bus.req[sum[RW-1:0]]) begin
          found               = 1'b1;
          gnt_c[sum[RW-1:0]]  = 1'b1;
          gnt_idx             = sum[RW-1:0];
        end
      end
    end
  end

  always_comb begin
    wdata_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_c[i]) wdata_c = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign wen_c = found;
  assign ren_c = !rst && bus.rd_req && !empty_c;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rr_d        = rr_q;
    rd_valid_d  = ren_c;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wen_c) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      rr_d     = (gnt_idx == RW'(NREQ-1)) ? '0 : gnt_idx + RW'(1);
    end
    if (ren_c) rd_ptr_d = rd_ptr_q + PTR_ONE;

    if (wen_c && !ren_c)      count_d = count_q + PTR_ONE;
    else if (ren_c && !wen_c) count_d = count_q - PTR_ONE;

    // A set condition in the same cycle as flag_clr keeps the flag set.
    if (full_c && |bus.req)          overflow_d = 1'b1;
    else if (bus.flag_clr)           overflow_d = 1'b0;
    if (empty_c && bus.rd_req)       underflow_d = 1'b1;
    else if (bus.flag_clr)           underflow_d = 1'b0;
  end

  always_ff @(posedge wclk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rr_q        <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rr_q        <= rr_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.mem_wen   = wen_c;
  assign bus.mem_waddr = wr_ptr_q[ASIZE-1:0];
  assign bus.mem_wdata = wdata_c;
  assign bus.mem_ren   = ren_c;
  assign bus.mem_raddr = rd_ptr_q[ASIZE-1:0];
  assign bus.rd_valid  = rd_valid_q;
  assign bus.count     = count_q;
  assign bus.full      = full_c;
  assign bus.empty     = empty_c;
  assign bus.threshold = (count_q >= THR);
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Directed bench for fifo_port_arbiter with a behavioural 16x8 storage array on the memory ports.
module tb_fifo_port_arbiter;
  logic wclk = 1'b0;
  logic rst;
  always #5 wclk = ~wclk;

  fifo_port_arbiter_if #(.DATA_WIDTH(8), .ASIZE(4), .NREQ(4)) bus ();

  fifo_port_arbiter #(.DATA_WIDTH(8), .ASIZE(4), .NREQ(4), .THRESH(12)) dut (
    .wclk (wclk),
    .rst  (rst),
    .bus  (bus)
  );

  logic [7:0] mem [16];
  logic [7:0] mem_rdata;
  always @(posedge wclk) begin
    if (bus.mem_wen) mem[bus.mem_waddr] <= bus.mem_wdata;
    if (bus.mem_ren) mem_rdata <= mem[bus.mem_raddr];
  end

  int pass_cnt = 0;
  int total = 0;

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req      = '0;
    bus.req_data = '0;
    bus.rd_req   = 1'b0;
    bus.flag_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 4'hF; bus.req_data = 32'hA3A2A1A0; bus.rd_req = 1'b1; bus.flag_clr = 1'b0;
    #2;
    total++; if (bus.gnt !== 4'b0000) $display("FAIL rst_gnt_forced got %b want 0000", bus.gnt); else pass_cnt++;
    total++; if (bus.mem_wen !== 1'b0 || bus.mem_ren !== 1'b0)
      $display("FAIL rst_mem_en_forced got wen=%b ren=%b want 0 0", bus.mem_wen, bus.mem_ren); else pass_cnt++;
    tick(); tick();
    rst = 1'b0;
    idle_inputs();
    #2;
    total++; if (bus.count !== 5'd0) $display("FAIL rst_count got %0d want 0", bus.count); else pass_cnt++;
    total++; if ({bus.empty, bus.full, bus.threshold} !== 3'b100)
      $display("FAIL rst_flags got empty/full/thr=%b want 100", {bus.empty, bus.full, bus.threshold}); else pass_cnt++;
    total++; if ({bus.rd_valid, bus.overflow, bus.underflow} !== 3'b000)
      $display("FAIL rst_rdv_err got %b want 000", {bus.rd_valid, bus.overflow, bus.underflow}); else pass_cnt++;
  endtask

  task automatic test_round_robin_all();
    logic [3:0] exp_g;
    bus.req_data = 32'hA3A2A1A0;
    bus.req = 4'hF;
    for (int c = 0; c < 4; c++) begin
      exp_g = 4'b0001 << c;
      #2;
      total++; if (bus.gnt !== exp_g) $display("FAIL rr_all_gnt%0d got %b want %b", c, bus.gnt, exp_g); else pass_cnt++;
      total++; if (bus.mem_waddr !== 4'(c) || bus.mem_wdata !== 8'(8'hA0 + c))
        $display("FAIL rr_all_write%0d got addr=%0d data=%h want addr=%0d data=%h",
                 c, bus.mem_waddr, bus.mem_wdata, c, 8'(8'hA0 + c)); else pass_cnt++;
      tick();
    end
    bus.req = '0;
    #2;
    total++; if (bus.count !== 5'd4) $display("FAIL rr_all_count got %0d want 4", bus.count); else pass_cnt++;
  endtask

  task automatic test_round_robin_sparse();
    logic [3:0] exp_seq [3];
    exp_seq[0] = 4'b0010; exp_seq[1] = 4'b1000; exp_seq[2] = 4'b0010;
    do_reset();
    bus.req = 4'b1010;
    bus.req_data = 32'hB3B2B1B0;
    for (int c = 0; c < 3; c++) begin
      #2;
      total++; if (bus.gnt !== exp_seq[c]) $display("FAIL rr_sparse_gnt%0d got %b want %b", c, bus.gnt, exp_seq[c]); else pass_cnt++;
      tick();
    end
    bus.req = '0;
    #2;
    total++; if (bus.count !== 5'd3) $display("FAIL rr_sparse_count got %0d want 3", bus.count); else pass_cnt++;
  endtask

  task automatic test_full_overflow();
    do_reset();
    bus.req = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      bus.req_data = {24'h0, 8'(8'h10 + i)};
      #2;
      if (i == 11 || i == 12) begin
        total++; if (bus.threshold !== (i >= 12))
          $display("FAIL thr_at_count%0d got %b want %b", i, bus.threshold, (i >= 12)); else pass_cnt++;
      end
      tick();
    end
    #2;
    total++; if (bus.count !== 5'd16 || bus.full !== 1'b1)
      $display("FAIL full_count got count=%0d full=%b want 16 1", bus.count, bus.full); else pass_cnt++;
    total++; if (bus.gnt !== 4'b0000 || bus.mem_wen !== 1'b0)
      $display("FAIL full_blocks_gnt got gnt=%b wen=%b want 0000 0", bus.gnt, bus.mem_wen); else pass_cnt++;
    tick();
    tick();
    total++; if (bus.overflow !== 1'b1) $display("FAIL overflow_set got %b want 1", bus.overflow); else pass_cnt++;
    bus.flag_clr = 1'b1;
    tick();
    total++; if (bus.overflow !== 1'b1) $display("FAIL overflow_set_wins got %b want 1", bus.overflow); else pass_cnt++;
    bus.req = '0;
    tick();
    bus.flag_clr = 1'b0;
    #2;
    total++; if (bus.overflow !== 1'b0 || bus.count !== 5'd16)
      $display("FAIL overflow_clr got ovf=%b count=%0d want 0 16", bus.overflow, bus.count); else pass_cnt++;
  endtask

  task automatic test_full_pop();
    bus.req = 4'b0001;
    bus.req_data = 32'h00000077;
    bus.rd_req = 1'b1;
    #2;
    total++; if (bus.gnt !== 4'b0000 || bus.mem_ren !== 1'b1)
      $display("FAIL full_pop_nogrant got gnt=%b ren=%b want 0000 1", bus.gnt, bus.mem_ren); else pass_cnt++;
    tick();
    #1;
    total++; if (bus.count !== 5'd15 || bus.gnt !== 4'b0001)
      $display("FAIL full_pop_next got count=%0d gnt=%b want 15 0001", bus.count, bus.gnt); else pass_cnt++;
    total++; if (bus.rd_valid !== 1'b1 || mem_rdata !== 8'h10)
      $display("FAIL full_pop_data0 got v=%b d=%h want 1 10", bus.rd_valid, mem_rdata); else pass_cnt++;
    tick();
    #1;
    total++; if (bus.count !== 5'd15 || mem_rdata !== 8'h11)
      $display("FAIL full_pop_steady got count=%0d d=%h want 15 11", bus.count, mem_rdata); else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_underflow_single();
    do_reset();
    bus.rd_req = 1'b1;
    #2;
    total++; if (bus.mem_ren !== 1'b0) $display("FAIL empty_ren got %b want 0", bus.mem_ren); else pass_cnt++;
    tick();
    bus.rd_req = 1'b0;
    #2;
    total++; if (bus.rd_valid !== 1'b0 || bus.underflow !== 1'b1)
      $display("FAIL underflow_set got v=%b uf=%b want 0 1", bus.rd_valid, bus.underflow); else pass_cnt++;
    bus.req = 4'b0100;
    bus.req_data = 32'h005A0000;
    #1;
    total++; if (bus.gnt !== 4'b0100 || bus.mem_wdata !== 8'h5A || bus.mem_waddr !== 4'd0)
      $display("FAIL single_write got gnt=%b d=%h a=%0d want 0100 5a 0", bus.gnt, bus.mem_wdata, bus.mem_waddr); else pass_cnt++;
    tick();
    bus.req = '0;
    bus.rd_req = 1'b1;
    #2;
    total++; if (bus.mem_ren !== 1'b1 || bus.mem_raddr !== 4'd0 || bus.underflow !== 1'b1)
      $display("FAIL single_pop got ren=%b a=%0d uf=%b want 1 0 1", bus.mem_ren, bus.mem_raddr, bus.underflow); else pass_cnt++;
    tick();
    bus.rd_req = 1'b0;
    #2;
    total++; if (bus.rd_valid !== 1'b1 || mem_rdata !== 8'h5A || bus.empty !== 1'b1)
      $display("FAIL single_readback got v=%b d=%h empty=%b want 1 5a 1", bus.rd_valid, mem_rdata, bus.empty); else pass_cnt++;
  endtask

  task automatic test_stream_and_reset();
    do_reset();
    bus.req = 4'b0001;
    bus.req_data = {24'h0, 8'(5)};
    #2;
    tick();
    for (int j = 1; j <= 40; j++) begin
      bus.req_data = {24'h0, 8'(j * 37 + 5)};
      bus.rd_req = 1'b1;
      #2;
      total++; if (bus.count !== 5'd1 || bus.gnt !== 4'b0001)
        $display("FAIL stream_count%0d got count=%0d gnt=%b want 1 0001", j, bus.count, bus.gnt); else pass_cnt++;
      tick();
      #1;
      total++; if (bus.rd_valid !== 1'b1 || mem_rdata !== 8'((j - 1) * 37 + 5))
        $display("FAIL stream_data%0d got v=%b d=%h want 1 %h", j, bus.rd_valid, mem_rdata, 8'((j - 1) * 37 + 5)); else pass_cnt++;
    end
    rst = 1'b1;
    #1;
    total++; if (bus.gnt !== 4'b0000 || bus.mem_ren !== 1'b0)
      $display("FAIL midrst_forced got gnt=%b ren=%b want 0000 0", bus.gnt, bus.mem_ren); else pass_cnt++;
    tick();
    rst = 1'b0;
    idle_inputs();
    #2;
    total++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.rd_valid !== 1'b0)
      $display("FAIL midrst_state got count=%0d empty=%b v=%b want 0 1 0", bus.count, bus.empty, bus.rd_valid); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_round_robin_all();
    test_round_robin_sparse();
    test_full_overflow();
    test_full_pop();
    test_underflow_single();
    test_stream_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
